pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 178 +++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Purpose: write-back pipeline stage register with valid/ready handshake, flush and occupancy.
// Latency: one cycle from accept to output; full throughput on simultaneous accept and release.
// Backpressure: default build has one entry with in_ready = ~out_valid | out_ready;
//   defining PIPE_STAGE_SKID_EN adds a skid entry so in_ready is a pure register output.
module pipe_stage_reg #(
   parameter int DATA_W = 64,
   parameter int CTRL_W = 3,
   parameter int RD_W   = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [RD_W-1:0]   in_rd,
   input  logic [DATA_W-1:0] in_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [RD_W-1:0]   out_rd,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
);

   // Main entry: the one presented on the outputs.
   logic              main_vld;
   logic              main_vld_nx;
   logic [CTRL_W-1:0] main_ctrl;
   logic [RD_W-1:0]   main_rd;
   logic [DATA_W-1:0] main_data;
   logic              load_main;
   logic              accept;
   logic              release_main;

   assign accept       = in_valid & in_ready;
   assign release_main = main_vld & out_ready;

   // Bubbles never carry write-back control; rd/data keep their last loaded values.
   assign out_valid = main_vld;
   assign out_ctrl  = main_vld ? main_ctrl : '0;
   assign out_rd    = main_rd;
   assign out_data  = main_data;

`ifdef PIPE_STAGE_SKID_EN

   // Skid entry catches the accept made while the main entry is stalled.
   logic              skid_vld;
   logic              skid_vld_nx;
   logic [CTRL_W-1:0] skid_ctrl;
   logic [RD_W-1:0]   skid_rd;
   logic [DATA_W-1:0] skid_data;
   logic              load_skid;
   logic              move_skid;

   // Ready straight from a flop: no combinational path from out_ready.
   assign in_ready  = ~skid_vld;
   assign occupancy = {1'b0, main_vld} + {1'b0, skid_vld};

   // Next-state: decide which entry loads, moves or empties this edge; flush wins.
   always_comb begin
      main_vld_nx = main_vld;
      skid_vld_nx = skid_vld;
      load_main   = 1'b0;
      load_skid   = 1'b0;
      move_skid   = 1'b0;
      if (flush) begin
         main_vld_nx = 1'b0;
         skid_vld_nx = 1'b0;
      end else if (release_main) begin
         if (skid_vld) begin
            // Skid drains into main; in_ready was low so nothing new arrives.
            move_skid   = 1'b1;
            skid_vld_nx = 1'b0;
            main_vld_nx = 1'b1;
         end else if (accept) begin
            load_main   = 1'b1;
            main_vld_nx = 1'b1;
         end else begin
            main_vld_nx = 1'b0;
         end
      end else if (accept) begin
         if (main_vld) begin
            load_skid   = 1'b1;
            skid_vld_nx = 1'b1;
         end else begin
            load_main   = 1'b1;
            main_vld_nx = 1'b1;
         end
      end
   end

   // Valid bits for both entries.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_vld <= 1'b0;
         skid_vld <= 1'b0;
      end else begin
         main_vld <= main_vld_nx;
         skid_vld <= skid_vld_nx;
      end
   end

   // Main payload: fresh input or the older skid contents.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_ctrl <= '0;
         main_rd   <= '0;
         main_data <= '0;
      end else if (load_main) begin
         main_ctrl <= in_ctrl;
         main_rd   <= in_rd;
         main_data <= in_data;
      end else if (move_skid) begin
         main_ctrl <= skid_ctrl;
         main_rd   <= skid_rd;
         main_data <= skid_data;
      end
   end

   // Skid payload: loaded only when main is stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         skid_ctrl <= '0;
         skid_rd   <= '0;
         skid_data <= '0;
      end else if (load_skid) begin
         skid_ctrl <= in_ctrl;
         skid_rd   <= in_rd;
         skid_data <= in_data;
      end
   end

`else

   // Single entry: ready when empty or being drained this cycle.
   assign in_ready  = ~main_vld | out_ready;
   assign occupancy = {1'b0, main_vld};

   // Next-state: flush empties; accept (re)fills, including same-edge replace.
   always_comb begin
      main_vld_nx = main_vld;
      load_main   = 1'b0;
      if (flush) begin
         main_vld_nx = 1'b0;
      end else if (accept) begin
         load_main   = 1'b1;
         main_vld_nx = 1'b1;
      end else if (release_main) begin
         main_vld_nx = 1'b0;
      end
   end

   // Valid bit for the single entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_vld <= 1'b0;
      end else begin
         main_vld <= main_vld_nx;
      end
   end

   // Payload register; holds while idle or stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_ctrl <= '0;
         main_rd   <= '0;
         main_data <= '0;
      end else if (load_main) begin
         main_ctrl <= in_ctrl;
         main_rd   <= in_rd;
         main_data <= in_data;
      end
   end

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg; default build plus skid-only vectors
// when PIPE_STAGE_SKID_EN is defined.
module tb_pipe_stage_reg;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_ctrl;
   logic [4:0]  in_rd;
   logic [63:0] in_data;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [2:0]  out_ctrl;
   logic [4:0]  out_rd;
   logic [63:0] out_data;
   logic [1:0]  occupancy;

   int errors = 0;
   int checks = 0;

   pipe_stage_reg dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_ctrl   (in_ctrl),
      .in_rd     (in_rd),
      .in_data   (in_data),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ctrl  (out_ctrl),
      .out_rd    (out_rd),
      .out_data  (out_data),
      .occupancy (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic exp_stall_rdy;

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_ctrl   = '0;
      in_rd     = '0;
      in_data   = '0;
      flush     = 1'b0;
      out_ready = 1'b0;
      #1;
      chk("rst_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_occ", {62'd0, occupancy}, 64'd0);
      chk("rst_ctrl", {61'd0, out_ctrl}, 64'd0);
      chk("rst_rd", {59'd0, out_rd}, 64'd0);
      chk("rst_data", out_data, 64'd0);
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("post_rst_rdy", {63'd0, in_ready}, 64'd1);

      // Streaming at full throughput.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         in_data = 64'(i);
         in_rd   = 5'(i);
         tick();
         chk($sformatf("stream_data%0d", i), out_data, 64'(i));
         chk($sformatf("stream_vld%0d", i), {63'd0, out_valid}, 64'd1);
         chk($sformatf("stream_occ%0d", i), {62'd0, occupancy}, 64'd1);
      end
      in_valid = 1'b0;
      tick();
      chk("stream_drain", {63'd0, out_valid}, 64'd0);

      // Control gated to zero on bubble; rd/data held.
      in_valid = 1'b1;
      in_ctrl  = 3'b101;
      in_rd    = 5'd7;
      in_data  = 64'h55;
      tick();
      chk("ctrl_live", {61'd0, out_ctrl}, 64'd5);
      in_valid = 1'b0;
      in_ctrl  = 3'b000;
      in_rd    = 5'd0;
      in_data  = 64'h0;
      tick();
      chk("ctrl_bubble_vld", {63'd0, out_valid}, 64'd0);
      chk("ctrl_bubble", {61'd0, out_ctrl}, 64'd0);
      chk("ctrl_hold_rd", {59'd0, out_rd}, 64'd7);
      chk("ctrl_hold_data", out_data, 64'h55);

      // Stall then same-edge replace.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_ctrl   = 3'b001;
      in_data   = 64'h66;
      tick();
      chk("stall_load", out_data, 64'h66);
      in_valid = 1'b0;
      in_data  = 64'h0;
      #1;
`ifdef PIPE_STAGE_SKID_EN
      exp_stall_rdy = 1'b1;
`else
      exp_stall_rdy = 1'b0;
`endif
      chk("stall_rdy", {63'd0, in_ready}, {63'd0, exp_stall_rdy});
      tick();
      tick();
      tick();
      chk("stall_hold_data", out_data, 64'h66);
      chk("stall_hold_vld", {63'd0, out_valid}, 64'd1);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 64'h77;
      #1;
      chk("replace_rdy", {63'd0, in_ready}, 64'd1);
      tick();
      chk("replace_data", out_data, 64'h77);
      chk("replace_vld", {63'd0, out_valid}, 64'd1);
      in_valid = 1'b0;
      tick();
      chk("replace_drain", {63'd0, out_valid}, 64'd0);

      // Flush with a concurrent accept.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_ctrl   = 3'b011;
      in_data   = 64'h88;
      tick();
      out_ready = 1'b1;
      flush     = 1'b1;
      in_data   = 64'hC;
      #1;
      chk("flush_rdy", {63'd0, in_ready}, 64'd1);
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("flush_vld", {63'd0, out_valid}, 64'd0);
      chk("flush_occ", {62'd0, occupancy}, 64'd0);
      chk("flush_ctrl", {61'd0, out_ctrl}, 64'd0);
      chk("flush_noC", {63'd0, out_data == 64'hC}, 64'd0);
      tick();
      chk("flush_after", {63'd0, out_valid}, 64'd0);

`ifdef PIPE_STAGE_SKID_EN
      // Skid fill and ordered drain.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 64'hA;
      tick();
      chk("skid_a_occ", {62'd0, occupancy}, 64'd1);
      chk("skid_a_rdy", {63'd0, in_ready}, 64'd1);
      in_data = 64'hB;
      tick();
      in_valid = 1'b0;
      chk("skid_full_occ", {62'd0, occupancy}, 64'd2);
      chk("skid_full_rdy", {63'd0, in_ready}, 64'd0);
      chk("skid_head_a", out_data, 64'hA);
      out_ready = 1'b1;
      tick();
      chk("skid_out_b", out_data, 64'hB);
      chk("skid_b_occ", {62'd0, occupancy}, 64'd1);
      chk("skid_rdy_back", {63'd0, in_ready}, 64'd1);
      tick();
      chk("skid_empty", {63'd0, out_valid}, 64'd0);

      // Flush from occupancy 2.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 64'h1;
      tick();
      in_data = 64'h2;
      tick();
      chk("skid_fl_occ2", {62'd0, occupancy}, 64'd2);
      flush   = 1'b1;
      in_data = 64'hC;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("skid_fl_vld", {63'd0, out_valid}, 64'd0);
      chk("skid_fl_occ", {62'd0, occupancy}, 64'd0);
      chk("skid_fl_ctrl", {61'd0, out_ctrl}, 64'd0);
      out_ready = 1'b1;
      tick();
      chk("skid_fl_noC", {63'd0, out_valid}, 64'd0);
`endif

      // Asynchronous reset between edges.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 64'h99;
      tick();
      in_valid = 1'b0;
      chk("arst_pre_occ", {62'd0, occupancy}, 64'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_vld", {63'd0, out_valid}, 64'd0);
      chk("arst_occ", {62'd0, occupancy}, 64'd0);
      chk("arst_data", out_data, 64'd0);
      #1;
      rst = 1'b0;
      tick();
      chk("arst_rdy", {63'd0, in_ready}, 64'd1);
      chk("arst_stay_empty", {63'd0, out_valid}, 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
